// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types and helpers for the perceptron trainer; PERCEPTRON_BIAS_EN widens the weight index
package perceptron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC  = 3'd1,
        ST_ACT  = 3'd2,
        ST_UPD  = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Index fields stay at least one bit wide so single-entry stores still get a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int widx_w(input int n_feat);
`ifdef PERCEPTRON_BIAS_EN
        return idx_w(n_feat + 1);
`else
        return idx_w(n_feat);
`endif
    endfunction

    function automatic int acc_w(input int dw, input int n_feat);
        return 2 * dw + $clog2(n_feat) + 1;
    endfunction

    function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/perceptron_mac_unit.sv
// rtl/perceptron_mac_unit.sv - signed multiply-accumulate with clear and saturating weight adder
module perceptron_mac_unit
    import perceptron_pkg::*;
#(
    parameter int DW       = 8,
    parameter int ACC_W    = 2 * DW + 2,
    parameter int LR_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [DW-1:0]    i_x,
    input  logic signed [DW-1:0]    i_w,
    input  logic                    i_upd_neg,
    output logic signed [ACC_W-1:0] o_acc,
    output logic signed [DW-1:0]    o_upd_w
);

    logic signed [2*DW-1:0]  w_prod;
    logic signed [DW-1:0]    w_term;
    logic signed [DW:0]      w_sum;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod = (2*DW)'(i_x) * (2*DW)'(i_w);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_acc = r_acc;

    // One extra bit holds any sum or difference of two DW-bit values before clamping.
    assign w_term  = i_x >>> LR_SHIFT;
    assign w_sum   = i_upd_neg ? ((DW+1)'(i_w) - (DW+1)'(w_term))
                               : ((DW+1)'(i_w) + (DW+1)'(w_term));
    assign o_upd_w = DW'(sat_dw(32'(w_sum), DW));

endmodule

// File: rtl/perceptron_train_ctrl.sv
// rtl/perceptron_train_ctrl.sv - perceptron training sequencer with weight file; PERCEPTRON_BIAS_EN adds a bias register
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_FEAT    = 2,
    parameter int N_SAMP    = 3,
    parameter int DW        = 8,
    parameter int MAX_EPOCH = 16,
    parameter int LR_SHIFT  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        converged,
    output logic [idx_w(N_SAMP)-1:0]    samp_idx,
    output logic [idx_w(N_FEAT)-1:0]    feat_idx,
    input  logic signed [DW-1:0]        x_data,
    input  logic                        y_label,
    input  logic                        w_ld_en,
    input  logic [widx_w(N_FEAT)-1:0]   w_ld_idx,
    input  logic signed [DW-1:0]        w_ld_data,
    input  logic [widx_w(N_FEAT)-1:0]   w_rd_idx,
    output logic signed [DW-1:0]        w_rd_data,
    output logic [7:0]                  epoch_cnt,
    output logic [7:0]                  err_cnt
);

    localparam int SI_W  = idx_w(N_SAMP);
    localparam int FI_W  = idx_w(N_FEAT);
    localparam int WI_W  = widx_w(N_FEAT);
    localparam int ACC_W = acc_w(DW, N_FEAT);
    localparam logic [SI_W-1:0] LAST_SAMP = SI_W'(N_SAMP - 1);
    localparam logic [FI_W-1:0] LAST_FEAT = FI_W'(N_FEAT - 1);
    localparam logic [7:0]      EPOCH_CAP = 8'(MAX_EPOCH);

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_conv;
    logic                    r_neg;
    logic [SI_W-1:0]         r_samp;
    logic [FI_W-1:0]         r_feat;
    logic [7:0]              r_epoch;
    logic [7:0]              r_err;
    logic signed [DW-1:0]    r_w [N_FEAT];

    logic                    w_acc_clr;
    logic                    w_acc_en;
    logic                    w_act;
    logic                    w_wrong;
    logic signed [DW-1:0]    w_cur_w;
    logic signed [DW-1:0]    w_upd_w;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_score;

    assign w_cur_w   = r_w[r_feat];
    assign w_acc_clr = ((r_state == ST_IDLE) && start) || (r_state == ST_NEXT);
    assign w_acc_en  = (r_state == ST_MAC);

    perceptron_mac_unit #(
        .DW       (DW),
        .ACC_W    (ACC_W),
        .LR_SHIFT (LR_SHIFT)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_acc_clr),
        .i_en      (w_acc_en),
        .i_x       (x_data),
        .i_w       (w_cur_w),
        .i_upd_neg (r_neg),
        .o_acc     (w_acc),
        .o_upd_w   (w_upd_w)
    );

`ifdef PERCEPTRON_BIAS_EN
    localparam int B_SH = ((DW / 2 - 1 - LR_SHIFT) > 0) ? (DW / 2 - 1 - LR_SHIFT) : 0;
    localparam logic signed [DW:0] B_STEP = (DW+1)'(1 << B_SH);

    logic signed [DW-1:0] r_b;
    logic signed [DW:0]   w_b_sum;
    logic signed [DW-1:0] w_b_upd;

    assign w_score = w_acc + ACC_W'(r_b);
    assign w_b_sum = r_neg ? ((DW+1)'(r_b) - B_STEP) : ((DW+1)'(r_b) + B_STEP);
    assign w_b_upd = DW'(sat_dw(32'(w_b_sum), DW));
`else
    assign w_score = w_acc;
`endif

    assign w_act   = (w_score > 0);
    assign w_wrong = (y_label != w_act);

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (w_rd_idx == WI_W'(i)) w_rd_data = r_w[i];
        end
`ifdef PERCEPTRON_BIAS_EN
        if (w_rd_idx == WI_W'(N_FEAT)) w_rd_data = r_b;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_conv  <= 1'b0;
            r_neg   <= 1'b0;
            r_samp  <= '0;
            r_feat  <= '0;
            r_epoch <= '0;
            r_err   <= '0;
            for (int i = 0; i < N_FEAT; i++) r_w[i] <= '0;
`ifdef PERCEPTRON_BIAS_EN
            r_b     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ld_en) begin
                        for (int i = 0; i < N_FEAT; i++) begin
                            if (w_ld_idx == WI_W'(i)) r_w[i] <= w_ld_data;
                        end
`ifdef PERCEPTRON_BIAS_EN
                        if (w_ld_idx == WI_W'(N_FEAT)) r_b <= w_ld_data;
`endif
                    end
                    if (start) begin
                        r_epoch <= '0;
                        r_err   <= '0;
                        r_conv  <= 1'b0;
                        r_samp  <= '0;
                        r_feat  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_feat == LAST_FEAT) r_state <= ST_ACT;
                    else                     r_feat  <= r_feat + 1'b1;
                end
                ST_ACT: begin
                    if (w_wrong) begin
                        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                        // A wrong positive call means the label was 0: step weights down.
                        r_neg   <= w_act;
                        r_feat  <= '0;
                        r_state <= ST_UPD;
                    end else begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_UPD: begin
                    r_w[r_feat] <= w_upd_w;
`ifdef PERCEPTRON_BIAS_EN
                    if (r_feat == '0) r_b <= w_b_upd;
`endif
                    if (r_feat == LAST_FEAT) r_state <= ST_NEXT;
                    else                     r_feat  <= r_feat + 1'b1;
                end
                ST_NEXT: begin
                    r_feat <= '0;
                    if (r_samp != LAST_SAMP) begin
                        r_samp  <= r_samp + 1'b1;
                        r_state <= ST_MAC;
                    end else begin
                        r_epoch <= r_epoch + 8'd1;
                        if (r_err == 8'd0) begin
                            r_conv  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if ((r_epoch + 8'd1) == EPOCH_CAP) begin
                            r_conv  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_samp  <= '0;
                            r_err   <= '0;
                            r_state <= ST_MAC;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign converged = r_conv;
    assign samp_idx  = r_samp;
    assign feat_idx  = r_feat;
    assign epoch_cnt = r_epoch;
    assign err_cnt   = r_err;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// tb/tb_perceptron_train_ctrl.sv - randomized bench for perceptron_train_ctrl against a behavioural training model
module tb_perceptron_train_ctrl;

    localparam int NF  = 2;
    localparam int NS  = 3;
    localparam int DW  = 8;
    localparam int CAP = 4;
    localparam int LR  = 0;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 converged;
    logic [1:0]           samp_idx;
    logic [0:0]           feat_idx;
    logic signed [DW-1:0] x_data;
    logic                 y_label;
    logic                 w_ld_en;
    logic [0:0]           w_ld_idx;
    logic signed [DW-1:0] w_ld_data;
    logic [0:0]           w_rd_idx;
    logic signed [DW-1:0] w_rd_data;
    logic [7:0]           epoch_cnt;
    logic [7:0]           err_cnt;

    always #5 clk = ~clk;

    perceptron_train_ctrl #(
        .N_FEAT    (NF),
        .N_SAMP    (NS),
        .DW        (DW),
        .MAX_EPOCH (CAP),
        .LR_SHIFT  (LR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .samp_idx  (samp_idx),
        .feat_idx  (feat_idx),
        .x_data    (x_data),
        .y_label   (y_label),
        .w_ld_en   (w_ld_en),
        .w_ld_idx  (w_ld_idx),
        .w_ld_data (w_ld_data),
        .w_rd_idx  (w_rd_idx),
        .w_rd_data (w_rd_data),
        .epoch_cnt (epoch_cnt),
        .err_cnt   (err_cnt)
    );

    int xs [NS][NF];
    int ys [NS];

    always_comb begin
        x_data  = '0;
        y_label = 1'b0;
        if (samp_idx < NS) begin
            x_data  = 8'(xs[samp_idx][feat_idx]);
            y_label = (ys[samp_idx] != 0);
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    int m_w [NF];
    int m_cycles, m_err, m_ep, m_conv;
    int q_k[$], q_w0[$], q_w1[$], q_err[$], q_ep[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Plays a whole training session in plain arithmetic; records busy length and per-sample checkpoints.
    task automatic model_run();
        int cyc, ep, err, fin;
        q_k.delete(); q_w0.delete(); q_w1.delete(); q_err.delete(); q_ep.delete();
        cyc = 0; ep = 0; fin = 0; err = 0; m_conv = 0;
        while (fin == 0) begin
            err = 0;
            for (int s = 0; s < NS; s++) begin
                int dot, act, delta;
                dot = 0;
                for (int f = 0; f < NF; f++) dot += xs[s][f] * m_w[f];
                act   = (dot > 0) ? 1 : 0;
                delta = ys[s] - act;
                cyc  += NF + 2;
                if (delta != 0) begin
                    err++;
                    cyc += NF;
                    for (int f = 0; f < NF; f++) m_w[f] = clamp(m_w[f] + delta * (xs[s][f] >>> LR));
                end
                if (s == NS - 1) begin
                    ep++;
                    if (err == 0) begin
                        m_conv = 1; fin = 1;
                    end else if (ep == CAP) begin
                        m_conv = 0; fin = 1;
                    end
                end
                if (fin == 0) begin
                    q_k.push_back(cyc + 1);
                    q_w0.push_back(m_w[0]);
                    q_w1.push_back(m_w[1]);
                    q_err.push_back((s == NS - 1) ? 0 : err);
                    q_ep.push_back(ep);
                end
            end
        end
        m_cycles = cyc; m_err = err; m_ep = ep;
    endtask

    task automatic read_w(input int f, output int v);
        w_rd_idx = 1'(f);
        #1;
        v = w_rd_data;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic load_w(input int f, input int v);
        w_ld_en   = 1'b1;
        w_ld_idx  = 1'(f);
        w_ld_data = 8'(v);
        @(negedge clk);
        w_ld_en   = 1'b0;
        m_w[f]    = v;
    endtask

    task automatic set_samp(input int s, input int a, input int b, input int y);
        xs[s][0] = a;
        xs[s][1] = b;
        ys[s]    = y;
    endtask

    task automatic session(input int ld_f, input int ld_v, input int poke_k);
        int qi, v;
        wait_idle();
        if (ld_f >= 0) begin
            w_ld_en   = 1'b1;
            w_ld_idx  = 1'(ld_f);
            w_ld_data = 8'(ld_v);
            m_w[ld_f] = ld_v;
        end
        model_run();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        w_ld_en = 1'b0;
        qi = 0;
        for (int k = 1; k <= m_cycles; k++) begin
            chk("busy", int'(busy), 1);
            chk("done_early", int'(done), 0);
            chk("conv_busy", int'(converged), 0);
            if (qi < q_k.size() && q_k[qi] == k) begin
                read_w(0, v); chk("ckpt_w0", v, q_w0[qi]);
                read_w(1, v); chk("ckpt_w1", v, q_w1[qi]);
                chk("ckpt_err", int'(err_cnt), q_err[qi]);
                chk("ckpt_epoch", int'(epoch_cnt), q_ep[qi]);
                qi++;
            end
            if (k == poke_k) begin
                start     = 1'b1;
                w_ld_en   = 1'b1;
                w_ld_idx  = 1'b0;
                w_ld_data = 8'sd77;
            end else if (k == poke_k + 1) begin
                start   = 1'b0;
                w_ld_en = 1'b0;
            end
            @(negedge clk);
        end
        start   = 1'b0;
        w_ld_en = 1'b0;
        chk("done", int'(done), 1);
        chk("busy_at_done", int'(busy), 0);
        chk("converged", int'(converged), m_conv);
        chk("epoch_cnt", int'(epoch_cnt), m_ep);
        chk("err_cnt", int'(err_cnt), m_err);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("conv_hold", int'(converged), m_conv);
        read_w(0, v); chk("final_w0", v, m_w[0]);
        read_w(1, v); chk("final_w1", v, m_w[1]);
    endtask

    initial begin
        int v;
        rst = 1'b1; start = 1'b0; w_ld_en = 1'b0;
        w_ld_idx = '0; w_ld_data = '0; w_rd_idx = '0;
        for (int s = 0; s < NS; s++) set_samp(s, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_conv", int'(converged), 0);
        chk("rst_samp", int'(samp_idx), 0);
        chk("rst_feat", int'(feat_idx), 0);
        chk("rst_epoch", int'(epoch_cnt), 0);
        chk("rst_err", int'(err_cnt), 0);
        read_w(0, v); chk("rst_w0", v, 0);
        read_w(1, v); chk("rst_w1", v, 0);
        rst = 1'b0;
        @(negedge clk);
        m_w[0] = 0; m_w[1] = 0;

        // separable set, no update
        load_w(0, 3); load_w(1, -2);
        set_samp(0, 2, 3, 0); set_samp(1, 4, 5, 1); set_samp(2, 4, 5, 1);
        session(-1, 0, 0);
        chk("pin_sep_cycles", m_cycles, 12);
        chk("pin_sep_conv", m_conv, 1);
        chk("pin_sep_epoch", m_ep, 1);
        chk("pin_sep_err", m_err, 0);
        chk("pin_sep_w0", m_w[0], 3);
        chk("pin_sep_w1", m_w[1], -2);

        // start and weight load pulsed while busy must be ignored
        session(-1, 0, 2);

        // load in the same cycle as start feeds epoch 0
        load_w(0, 0);
        session(0, 3, 0);
        chk("pin_ldstart_cycles", m_cycles, 12);

        // single update
        load_w(0, 4); load_w(1, 9);
        set_samp(0, 2, 3, 0); set_samp(1, 1, 1, 1); set_samp(2, -1, -1, 0);
        session(-1, 0, 0);
        chk("pin_upd_k", q_k[0], 7);
        chk("pin_upd_w0", q_w0[0], 2);
        chk("pin_upd_w1", q_w1[0], 6);
        chk("pin_upd_err", q_err[0], 1);

        // saturation on both rails
        load_w(0, 100); load_w(1, -128);
        set_samp(0, 100, 127, 1); set_samp(1, 0, 0, 0); set_samp(2, 0, 0, 0);
        session(-1, 0, 0);
        chk("pin_sat_w0", q_w0[0], 127);
        chk("pin_sat_w1", q_w1[0], -1);

        // epoch cap with contradictory labels
        load_w(0, 0); load_w(1, 0);
        set_samp(0, 1, 0, 0); set_samp(1, 1, 0, 1); set_samp(2, 1, 0, 1);
        session(-1, 0, 0);
        chk("pin_cap_conv", m_conv, 0);
        chk("pin_cap_epoch", m_ep, 4);
        chk("pin_cap_err", m_err, 2);

        // reset in the middle of MAC
        wait_idle();
        load_w(0, 5); load_w(1, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_epoch", int'(epoch_cnt), 0);
        chk("mid_rst_err", int'(err_cnt), 0);
        read_w(0, v); chk("mid_rst_w0", v, 0);
        read_w(1, v); chk("mid_rst_w1", v, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", int'(done), 0);
            chk("mid_rst_idle", int'(busy), 0);
        end
        m_w[0] = 0; m_w[1] = 0;

        // randomized sessions
        for (int it = 0; it < 24; it++) begin
            int span;
            span = (it % 2 == 0) ? 8 : 128;
            load_w(0, int'($urandom_range(0, 2 * span - 1)) - span);
            load_w(1, int'($urandom_range(0, 2 * span - 1)) - span);
            for (int s = 0; s < NS; s++) begin
                set_samp(s, int'($urandom_range(0, 2 * span - 1)) - span,
                            int'($urandom_range(0, 2 * span - 1)) - span,
                            int'($urandom_range(0, 1)));
            end
            session(-1, 0, (it % 3 == 0) ? int'($urandom_range(1, 8)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
